// File: rtl/dft_memory_subsystem.sv
// dft_memory_subsystem: memory BIST, scan chain and stuck-at fault model under one clock
module dft_memory_subsystem #(
  parameter int MEM_DEPTH      = 4,
  parameter int SCAN_LEN       = 8,
  parameter int SA_BIT         = 3,
  parameter int SA_VAL         = 0,
  parameter int MEM_FAULT_EN   = 0,
  parameter int MEM_FAULT_ADDR = 2,
  parameter int MEM_FAULT_BIT  = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                bist_en,
  output logic                bist_done,
  output logic                bist_pass,
  output logic [7:0]          mem_out,
  input  logic                scan_en,
  input  logic                scan_in,
  output logic                scan_out,
  output logic [SCAN_LEN-1:0] q,
  input  logic [7:0]          test_vector,
  output logic                fault_detected
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam logic [AW-1:0] LAST = AW'(MEM_DEPTH - 1);
  localparam logic [7:0] FMASK = 8'(1) << MEM_FAULT_BIT;

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic                fail_q, fail_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [7:0]          mem_out_q, mem_out_d;
  logic [SCAN_LEN-1:0] q_q, q_d;
  logic                fd_q, fd_d;
  logic                we;
  logic [7:0]          pat, rd, mem [MEM_DEPTH];
  logic                mism;

  assign pat            = addr_q[0] ? 8'h55 : 8'hAA;
  assign rd             = mem[addr_q] | ((MEM_FAULT_EN != 0 && addr_q == AW'(MEM_FAULT_ADDR)) ? FMASK : 8'h00);
  assign mism           = rd != pat;
  assign bist_done      = done_q;
  assign bist_pass      = pass_q;
  assign mem_out        = mem_out_q;
  assign q              = q_q;
  assign scan_out       = q_q[SCAN_LEN-1];
  assign fault_detected = fd_q;

  // BIST sequencing: march addresses writing the background, then read back and compare
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    fail_d    = fail_q;
    done_d    = done_q;
    pass_d    = pass_q;
    mem_out_d = mem_out_q;
    we        = 1'b0;
    case (state_q)
      IDLE: if (bist_en) begin
        state_d = WRITE;
        addr_d  = '0;
        fail_d  = 1'b0;
        done_d  = 1'b0;
        pass_d  = 1'b0;
      end
      WRITE: if (!bist_en) state_d = IDLE;
      else begin
        we      = 1'b1;
        addr_d  = addr_q + 1'b1;
        state_d = addr_q == LAST ? READ : WRITE;
      end
      READ: if (!bist_en) state_d = IDLE;
      else begin
        mem_out_d = rd;
        fail_d    = fail_q | mism;
        addr_d    = addr_q + 1'b1;
        if (addr_q == LAST) begin
          state_d = DONE;
          done_d  = 1'b1;
          pass_d  = ~(fail_q | mism);
        end
      end
      default: if (!bist_en) state_d = IDLE;
    endcase
    q_d  = scan_en ? {q_q[SCAN_LEN-2:0], scan_in} : q_q;
    fd_d = test_vector[SA_BIT] != (SA_VAL != 0);
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      fail_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      mem_out_q <= '0;
      q_q       <= '0;
      fd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      fail_q    <= fail_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      mem_out_q <= mem_out_d;
      q_q       <= q_d;
      fd_q      <= fd_d;
    end
  end

  // Memory array is never cleared; only the BIST write phase updates it
  always_ff @(posedge clk) begin
    if (we) mem[addr_q] <= pat;
  end
endmodule

// File: tb/tb_dft_memory_subsystem.sv
// tb_dft_memory_subsystem: scoreboard bench for a fault-free and a fault-injected instance
module tb_dft_memory_subsystem;
  logic       clk = 1'b0, reset = 1'b1, bist_en = 1'b0, scan_en = 1'b0, scan_in = 1'b0;
  logic [7:0] test_vector = 8'h00;
  logic       done_a, pass_a, so_a, fd_a, done_b, pass_b, so_b, fd_b;
  logic [7:0] mo_a, mo_b, q_a, q_b;
  int         checks = 0, failures = 0;
  logic [7:0] exp_a[$], exp_b[$];

  always #5 clk = ~clk;

  dft_memory_subsystem dut_a (
    .clk(clk), .reset(reset), .bist_en(bist_en), .bist_done(done_a), .bist_pass(pass_a),
    .mem_out(mo_a), .scan_en(scan_en), .scan_in(scan_in), .scan_out(so_a), .q(q_a),
    .test_vector(test_vector), .fault_detected(fd_a)
  );

  dft_memory_subsystem #(.MEM_FAULT_EN(1), .SA_VAL(1)) dut_b (
    .clk(clk), .reset(reset), .bist_en(bist_en), .bist_done(done_b), .bist_pass(pass_b),
    .mem_out(mo_b), .scan_en(scan_en), .scan_in(scan_in), .scan_out(so_b), .q(q_b),
    .test_vector(test_vector), .fault_detected(fd_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_mem();
    if (exp_a.size() == 0 || exp_b.size() == 0) chk("sb_empty", 1, 0);
    else begin
      chk("mem_out_a", mo_a, exp_a.pop_front());
      chk("mem_out_b", mo_b, exp_b.pop_front());
    end
  endtask

  task automatic bist_run(input string tag);
    exp_a = {8'hAA, 8'h55, 8'hAA, 8'h55};
    exp_b = {8'hAA, 8'h55, 8'hAB, 8'h55};
    bist_en = 1'b1;
    step();
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i >= 5) pop_mem();
      if (i == 7) chk({tag, "_done_early"}, done_a, 0);
    end
    chk({tag, "_done_a"}, done_a, 1);
    chk({tag, "_pass_a"}, pass_a, 1);
    chk({tag, "_done_b"}, done_b, 1);
    chk({tag, "_pass_b"}, pass_b, 0);
    step();
    bist_en = 1'b0;
    step();
    step();
    chk({tag, "_hold_done"}, done_a, 1);
    chk({tag, "_hold_pass"}, pass_a, 1);
    chk({tag, "_hold_mo"}, mo_a, 8'h55);
  endtask

  initial begin
    logic [7:0] tv [4] = '{8'h00, 8'h08, 8'hF7, 8'h00};
    logic       si [6] = '{0, 1, 1, 0, 0, 0};
    logic [7:0] qs [6] = '{8'h00, 8'h01, 8'h03, 8'h06, 8'h0C, 8'h18};
    logic [7:0] sq[$];
    logic       fa[$], fb[$];
    #1;
    chk("rst_done", done_a, 0);
    chk("rst_pass", pass_a, 0);
    chk("rst_mo", mo_a, 0);
    chk("rst_q", q_a, 0);
    chk("rst_so", so_a, 0);
    chk("rst_fd", fd_a, 0);
    step();
    reset = 1'b0;
    step();
    bist_run("run1");
    scan_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      scan_in = si[i];
      sq.push_back(qs[i]);
      step();
      chk("scan_q", q_a, sq.pop_front());
      chk("scan_out", so_a, 0);
    end
    scan_en = 1'b0;
    scan_in = 1'b1;
    step();
    step();
    chk("scan_hold", q_a, 8'h18);
    for (int i = 0; i < 4; i++) begin
      test_vector = tv[i];
      fa.push_back(tv[i][3] != 1'b0);
      fb.push_back(tv[i][3] != 1'b1);
      step();
      chk("fd_a", fd_a, fa.pop_front());
      chk("fd_b", fd_b, fb.pop_front());
    end
    bist_en = 1'b1;
    step();
    step();
    step();
    bist_en = 1'b0;
    step();
    chk("abort_done", done_a, 0);
    chk("abort_pass", pass_a, 0);
    chk("abort_mo", mo_a, 8'h55);
    step();
    step();
    chk("abort_idle_done", done_a, 0);
    bist_run("run2");
    test_vector = 8'h08;
    step();
    chk("fd_pre_rst", fd_a, 1);
    bist_en = 1'b1;
    for (int i = 0; i < 6; i++) step();
    reset = 1'b1;
    #1;
    chk("mid_rst_mo", mo_a, 0);
    chk("mid_rst_q", q_a, 0);
    chk("mid_rst_fd", fd_a, 0);
    chk("mid_rst_done", done_a, 0);
    bist_en = 1'b0;
    step();
    reset = 1'b0;
    step();
    bist_run("run3");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
